// File: rtl/subleq_core_param.sv
// subleq_core_param -- parametrised SUBLEQ execution core.
//
// Executes one instruction per pass: mem[b] <= mem[b] - mem[a], then branches
// to c when the result is <= 0, otherwise falls through to pc+3. A taken branch
// to a negative target halts the core. All memory traffic goes through a single
// req/ack port, so BRAM (zero-wait) and wait-stated memories both work.
//
// Parameters:
//   DW        data word width (signed two's complement)
//   AW        address width; addresses are taken from word bits [AW-1:0]
//   RESET_PC  PC loaded at reset and on start
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   clk_enable    global advance enable, low freezes all state (and ignores ack)
//   start         pulse: (re)start from RESET_PC, honoured only in IDLE / HALT
//   mem_req/we/addr/wdata   memory request, held stable until mem_ack
//   mem_rdata/mem_ack       read data and completion, sampled on the ack cycle
//   busy          core is not in IDLE or HALT
//   halted        core executed a taken branch to a negative target
//   pc_out        current PC
//   result_out    last ALU result
//   retired       completed-instruction count (wrapping)
//   step          only with SUBLEQ_STEP_EN: releases the core from PAUSE
//
// Build option: define SUBLEQ_STEP_EN to add the step input and a PAUSE state
// entered after every write-back.
//
// All outputs come straight from flops: the next-state logic computes both the
// next architectural state and the memory-port values that go with it.

module subleq_core_param #(
  parameter int DW       = 64,
  parameter int AW       = 16,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_enable,
  input  logic             start,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             halted,
  output logic [AW-1:0]    pc_out,
  output logic [DW-1:0]    result_out,
  output logic [CNT_W-1:0] retired
`ifdef SUBLEQ_STEP_EN
  ,
  input  logic             step
`endif
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RD_A  = 4'd1;
  localparam logic [3:0] S_RD_B  = 4'd2;
  localparam logic [3:0] S_RD_C  = 4'd3;
  localparam logic [3:0] S_RD_MA = 4'd4;
  localparam logic [3:0] S_RD_MB = 4'd5;
  localparam logic [3:0] S_EXEC  = 4'd6;
  localparam logic [3:0] S_WR_MB = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;
`ifdef SUBLEQ_STEP_EN
  localparam logic [3:0] S_PAUSE = 4'd9;
`endif

  localparam logic [AW-1:0]    PC_RST  = AW'(RESET_PC);
  localparam logic [AW-1:0]    PC_INC1 = AW'(32'd1);
  localparam logic [AW-1:0]    PC_INC2 = AW'(32'd2);
  localparam logic [AW-1:0]    PC_INC3 = AW'(32'd3);
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(32'd1);

  // Branch condition: zero or negative.
  function automatic logic is_leq(input logic [DW-1:0] v);
    is_leq = (v == {DW{1'b0}}) | v[DW-1];
  endfunction

  // States that own an outstanding memory transaction.
  function automatic logic is_mem_state(input logic [3:0] s);
    case (s)
      S_RD_A, S_RD_B, S_RD_C, S_RD_MA, S_RD_MB, S_WR_MB: is_mem_state = 1'b1;
      default:                                           is_mem_state = 1'b0;
    endcase
  endfunction

  // Architectural registers. Operands a/b only ever serve as addresses, so
  // only their low AW bits are kept; c keeps its sign bit for the halt test.
  logic [3:0]       state_r,   state_s;
  logic [AW-1:0]    pc_r,      pc_s;
  logic [AW-1:0]    a_r,       a_s;
  logic [AW-1:0]    b_r,       b_s;
  logic [AW-1:0]    c_r,       c_s;
  logic             c_neg_r,   c_neg_s;
  logic [DW-1:0]    ma_r,      ma_s;
  logic [DW-1:0]    mb_r,      mb_s;
  logic [DW-1:0]    result_r,  result_s;
  logic [CNT_W-1:0] retired_r, retired_s;
  logic             halted_r,  halted_s;

  // Registered port outputs.
  logic             mem_req_r,   mem_req_s;
  logic             mem_we_r,    mem_we_s;
  logic [AW-1:0]    mem_addr_r,  mem_addr_s;
  logic [DW-1:0]    mem_wdata_r, mem_wdata_s;
  logic             busy_r,      busy_s;

  logic leq_s;
  logic halt_take_s;

  // Branch decision from the result computed in EXEC; stable through WR_MB/PAUSE.
  always_comb begin
    leq_s       = is_leq(result_r);
    halt_take_s = leq_s & c_neg_r;
  end

  // Next-state and datapath update; nothing advances while clk_enable is low.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    a_s       = a_r;
    b_s       = b_r;
    c_s       = c_r;
    c_neg_s   = c_neg_r;
    ma_s      = ma_r;
    mb_s      = mb_r;
    result_s  = result_r;
    retired_s = retired_r;
    halted_s  = halted_r;
    if (clk_enable) begin
      case (state_r)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_s   = S_RD_A;
            pc_s      = PC_RST;
            retired_s = {CNT_W{1'b0}};
            halted_s  = 1'b0;
          end else begin
            state_s = state_r;
          end
        end
        S_RD_A: begin
          if (mem_ack) begin
            a_s     = mem_rdata[AW-1:0];
            state_s = S_RD_B;
          end else begin
            state_s = S_RD_A;
          end
        end
        S_RD_B: begin
          if (mem_ack) begin
            b_s     = mem_rdata[AW-1:0];
            state_s = S_RD_C;
          end else begin
            state_s = S_RD_B;
          end
        end
        S_RD_C: begin
          if (mem_ack) begin
            c_s     = mem_rdata[AW-1:0];
            c_neg_s = mem_rdata[DW-1];
            state_s = S_RD_MA;
          end else begin
            state_s = S_RD_C;
          end
        end
        S_RD_MA: begin
          if (mem_ack) begin
            ma_s    = mem_rdata;
            state_s = S_RD_MB;
          end else begin
            state_s = S_RD_MA;
          end
        end
        S_RD_MB: begin
          if (mem_ack) begin
            mb_s    = mem_rdata;
            state_s = S_EXEC;
          end else begin
            state_s = S_RD_MB;
          end
        end
        S_EXEC: begin
          result_s = mb_r - ma_r;
          state_s  = S_WR_MB;
        end
        S_WR_MB: begin
          if (mem_ack) begin
            retired_s = retired_r + CNT_INC;
            // A halting branch leaves pc pointing at the halting instruction.
            if (leq_s && !c_neg_r) begin
              pc_s = c_r;
            end else if (!leq_s) begin
              pc_s = pc_r + PC_INC3;
            end else begin
              pc_s = pc_r;
            end
`ifdef SUBLEQ_STEP_EN
            state_s = S_PAUSE;
`else
            if (halt_take_s) begin
              state_s  = S_HALT;
              halted_s = 1'b1;
            end else begin
              state_s = S_RD_A;
            end
`endif
          end else begin
            state_s = S_WR_MB;
          end
        end
`ifdef SUBLEQ_STEP_EN
        S_PAUSE: begin
          // start is deliberately not decoded here.
          if (step) begin
            if (halt_take_s) begin
              state_s  = S_HALT;
              halted_s = 1'b1;
            end else begin
              state_s = S_RD_A;
            end
          end else begin
            state_s = S_PAUSE;
          end
        end
`endif
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Port values for the state being entered, so the outputs can be flopped.
  always_comb begin
    mem_req_s   = is_mem_state(state_s);
    mem_we_s    = (state_s == S_WR_MB);
    mem_wdata_s = result_s;
    busy_s      = (state_s != S_IDLE) && (state_s != S_HALT);
    case (state_s)
      S_RD_A:           mem_addr_s = pc_s;
      S_RD_B:           mem_addr_s = pc_s + PC_INC1;
      S_RD_C:           mem_addr_s = pc_s + PC_INC2;
      S_RD_MA:          mem_addr_s = a_s;
      S_RD_MB, S_WR_MB: mem_addr_s = b_s;
      default:          mem_addr_s = mem_addr_r;
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pc_r        <= PC_RST;
      a_r         <= {AW{1'b0}};
      b_r         <= {AW{1'b0}};
      c_r         <= {AW{1'b0}};
      c_neg_r     <= 1'b0;
      ma_r        <= {DW{1'b0}};
      mb_r        <= {DW{1'b0}};
      result_r    <= {DW{1'b0}};
      retired_r   <= {CNT_W{1'b0}};
      halted_r    <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      a_r         <= a_s;
      b_r         <= b_s;
      c_r         <= c_s;
      c_neg_r     <= c_neg_s;
      ma_r        <= ma_s;
      mb_r        <= mb_s;
      result_r    <= result_s;
      retired_r   <= retired_s;
      halted_r    <= halted_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      busy_r      <= busy_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign halted     = halted_r;
  assign pc_out     = pc_r;
  assign result_out = result_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_subleq_core_param.sv
// Scoreboard bench for subleq_core_param (DW=16, AW=8).
// A SUBLEQ interpreter runs each program on a copy of memory and queues the
// expected write-backs; a memory responder serves the DUT (optionally with
// random wait states and clk_enable gaps) and a monitor pops and compares
// every completed write.

module tb_subleq_core_param;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_enable;
  logic          start;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata, mem_rdata, result_out;
  logic          busy, halted;
  logic [15:0]   retired;
`ifdef SUBLEQ_STEP_EN
  logic          step = 1'b1;
`endif

  subleq_core_param #(.DW(DW), .AW(AW), .RESET_PC(0), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .start      (start),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .halted     (halted),
    .pc_out     (pc_out),
    .result_out (result_out),
    .retired    (retired)
`ifdef SUBLEQ_STEP_EN
    , .step     (step)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] addr; logic [15:0] data;} wr_t;

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] rmem [256];
  wr_t           exp_q [$];
  int            errors = 0;
  int            checks = 0;
  bit            ws_mode = 1'b0;
  logic [7:0]    exp_pc1, exp_pc;
  int            exp_cnt;
  bit            exp_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after a random delay, applies completed writes,
  // and checks that a pending request stays stable until acknowledged.
  initial begin : responder
    int         wait_left;
    logic       prev_req, prev_done, prev_we;
    logic [7:0] prev_addr;
    logic [15:0] prev_wdata;
    wait_left = 0; prev_req = 1'b0; prev_done = 1'b0; prev_we = 1'b0;
    prev_addr = 8'd0; prev_wdata = 16'd0;
    mem_ack = 1'b0; clk_enable = 1'b1; mem_rdata = 16'd0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        prev_req = 1'b0; mem_ack = 1'b0; clk_enable = 1'b1; wait_left = 0;
      end else begin
        if (prev_req && !prev_done)
          chk("req_stable", {mem_req, mem_we, mem_addr, mem_wdata},
              {1'b1, prev_we, prev_addr, prev_wdata});
        clk_enable = (!ws_mode || start) ? 1'b1 : ($urandom_range(0, 3) != 0);
        mem_ack    = 1'b0;
        mem_rdata  = 16'($urandom);
        prev_done  = 1'b0;
        if (mem_req) begin
          if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            if (clk_enable) begin
              prev_done = 1'b1;
              if (mem_we) mem[mem_addr] = mem_wdata;
              wait_left = ws_mode ? int'($urandom_range(0, 5)) : 0;
            end
          end else if (clk_enable) begin
            wait_left--;
          end
        end
        prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
      end
    end
  end

  // Monitor: every write that completes this cycle must match the queue head.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && mem_req && mem_we && mem_ack && clk_enable) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  // Reference interpreter: plain SUBLEQ semantics on a copy of memory.
  task automatic ref_run(input int kmax);
    logic [7:0]  pc, p1, p2, a, b;
    logic [15:0] c, r;
    for (int i = 0; i < 256; i++) rmem[i] = mem[i];
    pc = 8'd0; exp_cnt = 0; exp_halt = 1'b0; exp_pc1 = 8'd0;
    while (!exp_halt && exp_cnt < kmax) begin
      p1 = pc + 8'd1; p2 = pc + 8'd2;
      a = rmem[pc][7:0]; b = rmem[p1][7:0]; c = rmem[p2];
      r = rmem[b] - rmem[a];
      rmem[b] = r;
      exp_q.push_back(wr_t'({b, r}));
      exp_cnt++;
      if ($signed(r) <= 0) begin
        if ($signed(c) < 0) exp_halt = 1'b1;
        else pc = c[7:0];
      end else begin
        pc = pc + 8'd3;
      end
      if (exp_cnt == 1) exp_pc1 = pc;
    end
    exp_pc = pc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
  endtask

  // Halting instruction: mem[8] -= mem[9] (both 0), branch to -1.
  task automatic put_halt(input logic [7:0] at);
    logic [7:0] p1, p2;
    p1 = at + 8'd1; p2 = at + 8'd2;
    mem[at] = 16'd9; mem[p1] = 16'd8; mem[p2] = 16'hFFFF;
  endtask

  task automatic load_prog(input logic [15:0] c0, input logic [15:0] m6, input logic [15:0] m7,
                           input logic [7:0] halt_at);
    clear_mem();
    mem[0] = 16'd6; mem[1] = 16'd7; mem[2] = c0; mem[6] = m6; mem[7] = m7;
    put_halt(halt_at);
  endtask

  task automatic start_core();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #3 rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_prog(input int kmax);
    int cyc;
    int diff;
    ref_run(kmax);
    start_core();
    chk("start_busy", busy, 1); chk("start_halted", halted, 0);
    chk("start_retired", retired, 0); chk("start_pc", pc_out, 0);
    cyc = 0;
    while (retired == 16'd0 && cyc < 2000) begin @(negedge clk); cyc++; end
    if (retired == 16'd0) begin
      checks++; errors++; $display("FAIL first_retire_timeout: got none expected retire");
    end else begin
      if (!ws_mode) chk("first_latency", cyc, 7);
      chk("pc_after_first", pc_out, exp_pc1);
    end
    cyc = 0;
    while (!(exp_halt ? halted : (retired == 16'(exp_cnt))) && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    if (cyc >= 20000) begin
      checks++; errors++; $display("FAIL run_timeout: got retired=%0d expected %0d", retired, exp_cnt);
    end
    chk("final_halted", halted, exp_halt);
    chk("final_pc", pc_out, exp_pc);
    chk("final_retired", retired, 32'(exp_cnt));
    chk("final_busy", busy, !exp_halt);
    if (exp_halt) chk("halt_no_req", mem_req, 0);
    chk("queue_empty", exp_q.size(), 0);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) diff++;
    chk("mem_image", diff, 0);
    if (!exp_halt) do_reset();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    // T1a: reset values
    chk("rst_req", mem_req, 0); chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    chk("rst_pc", pc_out, 0); chk("rst_retired", retired, 0); chk("rst_result", result_out, 0);
    rst = 1'b0;

    // T1b: reset in the middle of RD_MB of the second instruction
    load_prog(16'd9, 16'd5, 16'd9, 8'd3);
    ref_run(100);
    start_core();
    cyc = 0;
    while (retired == 16'd0 && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (4) @(negedge clk);
    chk("t1_in_rdmb", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'd8});
    #3 rst = 1'b1; #1;
    chk("t1_req", mem_req, 0); chk("t1_busy", busy, 0); chk("t1_halted", halted, 0);
    chk("t1_pc", pc_out, 0); chk("t1_retired", retired, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    exp_q.delete();

    // T2 basic, T3 branch (zero and negative result), T4 halt and restart
    load_prog(16'd9, 16'd5, 16'd9, 8'd3);  run_prog(100);
    load_prog(16'd12, 16'd9, 16'd9, 8'd12); run_prog(100);
    load_prog(16'd12, 16'd9, 16'd2, 8'd12); run_prog(100);
    load_prog(16'hFFFF, 16'd1, 16'd1, 8'd3); run_prog(100);
    chk("t4_image", mem[7], 16'd0);
    run_prog(100);

    // Random programs, zero-wait
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_prog(30);
    end

    // T5: wait states and clk_enable gaps
    ws_mode = 1'b1;
    load_prog(16'd9, 16'd5, 16'd9, 8'd3);  run_prog(100);
    load_prog(16'd12, 16'd9, 16'd2, 8'd12); run_prog(100);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_prog(30);
    end
    ws_mode = 1'b0;

`ifdef SUBLEQ_STEP_EN
    // T6: core waits in PAUSE until step, then fetches from pc=3
    load_prog(16'd9, 16'd5, 16'd9, 8'd3);
    step = 1'b0;
    ref_run(100);
    start_core();
    cyc = 0;
    while (retired == 16'd0 && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (10) @(negedge clk);
    chk("t6_retired", retired, 1); chk("t6_busy", busy, 1); chk("t6_no_req", mem_req, 0);
    step = 1'b1; @(negedge clk); step = 1'b0;
    chk("t6_rd_a", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'd3});
    step = 1'b1;
    cyc = 0;
    while (!halted && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t6_halted", halted, 1);
    exp_q.delete();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
